// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: load extract/merge, GPR write port, bypass, trace, retire counter
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   ms_to_ws_valid/ws_allowin   handshake with the MEM stage (ws_allowin is always 1)
//   ms_*                        instruction payload from MEM
//   rf_we/rf_waddr/rf_wdata     register file write port
//   ws_fwd_*                    same-cycle bypass to decode
//   debug_wb_*                  retirement trace
//   retire_cnt                  count of retired instructions
module wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ms_to_ws_valid,
    output logic                  ws_allowin,
    input  logic [31:0]           ms_pc,
    input  logic                  ms_gr_we,
    input  logic [ADDR_WIDTH-1:0] ms_dest,
    input  logic [DATA_WIDTH-1:0] ms_alu_result,
    input  logic [2:0]            ms_ld_op,
    input  logic [DATA_WIDTH-1:0] ms_rt_value,
    input  logic [DATA_WIDTH-1:0] ms_ld_rdata,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  ws_fwd_valid,
    output logic [ADDR_WIDTH-1:0] ws_fwd_dest,
    output logic [DATA_WIDTH-1:0] ws_fwd_data,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum,
    output logic [DATA_WIDTH-1:0] debug_wb_rf_wdata,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;
    localparam logic [2:0] LD_LWL  = 3'd6;
    localparam logic [2:0] LD_LWR  = 3'd7;

    logic                  r_ws_valid;
    logic [31:0]           r_pc;
    logic                  r_gr_we;
    logic [ADDR_WIDTH-1:0] r_dest;
    logic [DATA_WIDTH-1:0] r_alu_result;
    logic [2:0]            r_ld_op;
    logic [DATA_WIDTH-1:0] r_rt_value;
    logic [DATA_WIDTH-1:0] r_ld_rdata;
    logic [CNT_WIDTH-1:0]  r_retire_cnt;

    logic                  w_ws_ready_go;
    logic                  w_ws_allowin;
    logic                  w_rf_we;
    logic [1:0]            w_off;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_lwl;
    logic [DATA_WIDTH-1:0] w_lwr;
    logic [DATA_WIDTH-1:0] w_result;

    // WB never stalls, so it can always take a new instruction.
    assign w_ws_ready_go = 1'b1;
    assign w_ws_allowin  = !r_ws_valid || w_ws_ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ws_valid   <= 1'b0;
            r_pc         <= '0;
            r_gr_we      <= 1'b0;
            r_dest       <= '0;
            r_alu_result <= '0;
            r_ld_op      <= '0;
            r_rt_value   <= '0;
            r_ld_rdata   <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_ws_allowin) begin
                r_ws_valid <= ms_to_ws_valid;
            end
            // Payload holds through bubbles so the trace keeps its last values.
            if (ms_to_ws_valid && w_ws_allowin) begin
                r_pc         <= ms_pc;
                r_gr_we      <= ms_gr_we;
                r_dest       <= ms_dest;
                r_alu_result <= ms_alu_result;
                r_ld_op      <= ms_ld_op;
                r_rt_value   <= ms_rt_value;
                r_ld_rdata   <= ms_ld_rdata;
            end
            // Every valid instruction retires on the edge that ends its WB cycle.
            if (r_ws_valid) begin
                r_retire_cnt <= r_retire_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign w_off = r_alu_result[1:0];

    always_comb begin
        w_byte   = 8'h00;
        w_half   = 16'h0000;
        w_lwl    = r_ld_rdata;
        w_lwr    = r_ld_rdata;
        w_result = r_alu_result;

        case (w_off)
            2'd0:    w_byte = r_ld_rdata[7:0];
            2'd1:    w_byte = r_ld_rdata[15:8];
            2'd2:    w_byte = r_ld_rdata[23:16];
            default: w_byte = r_ld_rdata[31:24];
        endcase

        // Halfword loads use only a[1]; a[0] misalignment is trapped upstream.
        w_half = w_off[1] ? r_ld_rdata[31:16] : r_ld_rdata[15:0];

        // LWL fills from the top with the low bytes of the word; LWR fills
        // from the bottom with the high bytes. Unfilled bytes keep old rt.
        case (w_off)
            2'd0:    w_lwl = {r_ld_rdata[7:0],  r_rt_value[23:0]};
            2'd1:    w_lwl = {r_ld_rdata[15:0], r_rt_value[15:0]};
            2'd2:    w_lwl = {r_ld_rdata[23:0], r_rt_value[7:0]};
            default: w_lwl = r_ld_rdata;
        endcase
        case (w_off)
            2'd0:    w_lwr = r_ld_rdata;
            2'd1:    w_lwr = {r_rt_value[31:24], r_ld_rdata[31:8]};
            2'd2:    w_lwr = {r_rt_value[31:16], r_ld_rdata[31:16]};
            default: w_lwr = {r_rt_value[31:8],  r_ld_rdata[31:24]};
        endcase

        case (r_ld_op)
            LD_NONE: w_result = r_alu_result;
            LD_LB:   w_result = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            LD_LBU:  w_result = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            LD_LH:   w_result = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            LD_LHU:  w_result = {{(DATA_WIDTH-16){1'b0}}, w_half};
            LD_LW:   w_result = r_ld_rdata;
            LD_LWL:  w_result = w_lwl;
            LD_LWR:  w_result = w_lwr;
            default: w_result = r_alu_result;
        endcase
    end

    // r0 writes are dropped here so neither the RF nor the trace sees them.
    assign w_rf_we = r_ws_valid && r_gr_we && (r_dest != '0);

    assign ws_allowin        = w_ws_allowin;
    assign rf_we             = w_rf_we;
    assign rf_waddr          = r_dest;
    assign rf_wdata          = w_result;
    assign ws_fwd_valid      = w_rf_we;
    assign ws_fwd_dest       = r_dest;
    assign ws_fwd_data       = w_result;
    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_dest;
    assign debug_wb_rf_wdata = w_result;
    assign retire_cnt        = r_retire_cnt;

endmodule
